approx_prod_accum: RTL and testbench

//  Downstream consumer of the 32x32 approximate multiplier's 64-bit product.

---
 rtl/approx_mult_pkg.sv | 19 +
 rtl/approx_prod_accum_if.sv | 38 +++
 rtl/approx_prod_accum.sv | 130 +++++++++++++
 tb/tb_approx_prod_accum.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate MAC datapath.
//   PROD_W / ACC_W / CNT_W : default product, accumulator and beat-counter widths
//   prod_t                 : one multiplier product (the multiplier's y output)
//   acc_state_t            : burst accumulator FSM states
package approx_mult_pkg;

    localparam int PROD_W = 64;
    localparam int ACC_W  = 72;
    localparam int CNT_W  = 16;

    typedef logic [PROD_W-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE,   // no beat of a burst seen yet
        ACCUM,  // burst open, accumulating
        HOLD    // burst result presented, waiting for the consumer
    } acc_state_t;

endpackage

// File: rtl/approx_prod_accum_if.sv
// Handshake bundle between a product source and the burst accumulator.
//   in_valid/in_ready   : product beat handshake (source -> accumulator)
//   in_prod             : unsigned product, PROD_W bits
//   in_precise          : precise_en value that produced in_prod
//   in_last             : final beat of the burst
//   out_valid/out_ready : burst result handshake (accumulator -> consumer)
//   out_acc             : saturated burst sum, ACC_W bits
//   out_count           : saturated beat count, CNT_W bits
//   out_mixed           : burst mixed precise and approximate beats
//   out_ovf             : accumulator or counter saturated during the burst
// Modports: master = product source / result consumer, slave = accumulator.
interface approx_prod_accum_if #(
    parameter int PROD_W = approx_mult_pkg::PROD_W,
    parameter int ACC_W  = approx_mult_pkg::ACC_W,
    parameter int CNT_W  = approx_mult_pkg::CNT_W
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_precise;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_mixed;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_precise, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_mixed, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_precise, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_mixed, out_ovf
    );
endinterface

// File: rtl/approx_prod_accum.sv
// Burst accumulator for approximate multiplier products.
// Sums a burst of unsigned products (saturating at ACC_W bits), counts the
// beats (saturating at CNT_W bits) and flags bursts that mixed precise and
// approximate products. The result is presented one cycle after the last beat
// and held until the consumer takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : approx_prod_accum_if.slave (beat input and result output)
// ACC_W must be >= PROD_W.
module approx_prod_accum #(
    parameter int PROD_W = approx_mult_pkg::PROD_W,
    parameter int ACC_W  = approx_mult_pkg::ACC_W,
    parameter int CNT_W  = approx_mult_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    approx_prod_accum_if.slave  bus
);
    import approx_mult_pkg::*;

    acc_state_t       state_reg, state_next;
    logic             ready_en_reg;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;
    logic             mixed_reg, mixed_next;
    logic             ovf_reg, ovf_next;

    logic             out_valid_reg;
    logic [ACC_W-1:0] out_acc_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_mixed_reg;
    logic             out_ovf_reg;

    logic             in_ready;
    logic             accept;
    logic             opening;
    logic [ACC_W-1:0] base;
    logic [CNT_W-1:0] base_cnt;
    logic [ACC_W:0]   sum;
    logic             acc_sat;
    logic             cnt_sat;

    // ready_en_reg keeps in_ready low during reset and until the first edge
    // after release. While a result is held, a beat is only taken if the
    // consumer takes the result on the same edge.
    assign in_ready = ready_en_reg & ((state_reg != HOLD) | bus.out_ready);

    always_comb begin
        accept  = bus.in_valid & in_ready;
        // Any beat taken outside ACCUM starts a fresh burst, so the running
        // totals and flags restart from zero instead of acc_reg/cnt_reg.
        opening  = (state_reg != ACCUM);
        base     = opening ? '0 : acc_reg;
        base_cnt = opening ? '0 : cnt_reg;

        // One extra bit catches the carry out of the accumulator.
        sum      = {1'b0, base} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
        acc_sat  = sum[ACC_W];
        acc_next = acc_sat ? '1 : sum[ACC_W-1:0];

        cnt_sat  = &base_cnt;
        cnt_next = cnt_sat ? base_cnt : base_cnt + CNT_W'(1);

        ovf_next   = (opening ? 1'b0 : ovf_reg) | acc_sat | cnt_sat;
        mode_next  = opening ? bus.in_precise : mode_reg;
        mixed_next = !opening & (mixed_reg | (bus.in_precise != mode_reg));

        state_next = state_reg;
        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) state_next = bus.in_last ? HOLD : ACCUM;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (!accept)         state_next = IDLE;
                    else if (bus.in_last) state_next = HOLD;
                    else                 state_next = ACCUM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ready_en_reg  <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            mode_reg      <= 1'b0;
            mixed_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_acc_reg   <= '0;
            out_count_reg <= '0;
            out_mixed_reg <= 1'b0;
            out_ovf_reg   <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            state_reg    <= state_next;
            if (accept) begin
                acc_reg   <= acc_next;
                cnt_reg   <= cnt_next;
                mode_reg  <= mode_next;
                mixed_reg <= mixed_next;
                ovf_reg   <= ovf_next;
            end
            // A new last beat wins over the handshake so back-to-back
            // results keep out_valid high.
            if (accept && bus.in_last) begin
                out_valid_reg <= 1'b1;
                out_acc_reg   <= acc_next;
                out_count_reg <= cnt_next;
                out_mixed_reg <= mixed_next;
                out_ovf_reg   <= ovf_next;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_acc   = out_acc_reg;
    assign bus.out_count = out_count_reg;
    assign bus.out_mixed = out_mixed_reg;
    assign bus.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_approx_prod_accum.sv
// Self-checking bench for approx_prod_accum. Two instances share one
// stimulus stream: ACC_W=72 (default) and ACC_W=64 (saturating case).
// The reference model records accepted beats and computes each burst result
// from plain arithmetic on the recorded list.
module tb_approx_prod_accum;
    import approx_mult_pkg::*;

    localparam logic [127:0] LIM72 = (128'd1 << 72) - 128'd1;
    localparam logic [127:0] LIM64 = (128'd1 << 64) - 128'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    approx_prod_accum_if #(.PROD_W(64), .ACC_W(72), .CNT_W(16)) bus72 ();
    approx_prod_accum_if #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) bus64 ();

    approx_prod_accum #(.PROD_W(64), .ACC_W(72), .CNT_W(16)) u_dut72 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus72)
    );

    approx_prod_accum #(.PROD_W(64), .ACC_W(64), .CNT_W(16)) u_dut64 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus64)
    );

    assign bus64.in_valid   = bus72.in_valid;
    assign bus64.in_prod    = bus72.in_prod;
    assign bus64.in_precise = bus72.in_precise;
    assign bus64.in_last    = bus72.in_last;
    assign bus64.out_ready  = bus72.out_ready;

    // Reference model state: beats of the open burst, last expected result.
    logic [127:0] q_prod[$];
    bit           q_prec[$];
    logic [127:0] last_acc72, last_acc64, last_cnt;
    bit           last_mixed, last_ovf72, last_ovf64;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_result();
        logic [127:0] total = '0;
        bit           mixed = 1'b0;
        int           n     = q_prod.size();
        foreach (q_prod[i]) begin
            total += q_prod[i];
            if (q_prec[i] != q_prec[0]) mixed = 1'b1;
        end
        last_acc72 = (total > LIM72) ? LIM72 : total;
        last_acc64 = (total > LIM64) ? LIM64 : total;
        last_cnt   = (n > 65535) ? 128'd65535 : 128'(n);
        last_mixed = mixed;
        last_ovf72 = (total > LIM72) || (n > 65535);
        last_ovf64 = (total > LIM64) || (n > 65535);
        $display("burst: beats=%0d sum=%0h mixed=%0d", n, total, mixed);
        check("valid72", bus72.out_valid, 1);
        check("acc72",   bus72.out_acc,   last_acc72);
        check("count72", bus72.out_count, last_cnt);
        check("mixed72", bus72.out_mixed, last_mixed);
        check("ovf72",   bus72.out_ovf,   last_ovf72);
        check("valid64", bus64.out_valid, 1);
        check("acc64",   bus64.out_acc,   last_acc64);
        check("ovf64",   bus64.out_ovf,   last_ovf64);
        q_prod.delete();
        q_prec.delete();
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic beat(input prod_t p, input bit prec, input bit last);
        int waited = 0;
        bus72.in_valid   = 1'b1;
        bus72.in_prod    = p;
        bus72.in_precise = prec;
        bus72.in_last    = last;
        #1;
        while (!bus72.in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus72.in_ready) begin
            check("ready_timeout", bus72.in_ready, 1);
            bus72.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        q_prod.push_back(128'(p));
        q_prec.push_back(prec);
        @(negedge clk);
        // Garbage on the data lines while idle must be ignored.
        bus72.in_valid   = 1'b0;
        bus72.in_prod    = {$urandom, $urandom};
        bus72.in_precise = 1'($urandom);
        bus72.in_last    = 1'($urandom);
        if (last) check_result();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Consumer stalls for n cycles; the result must stay put, no beat taken.
    task automatic hold_check(input int n);
        bus72.out_ready = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("hold_valid", bus72.out_valid, 1);
            check("hold_acc72", bus72.out_acc, last_acc72);
            check("hold_cnt",   bus72.out_count, last_cnt);
            check("hold_ready", bus72.in_ready, 0);
            check("hold_acc64", bus64.out_acc, last_acc64);
        end
        bus72.out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus72.in_valid   = 1'b0;
        bus72.in_prod    = '0;
        bus72.in_precise = 1'b0;
        bus72.in_last    = 1'b0;
        bus72.out_ready  = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", bus72.in_ready, 0);
        check("rst_valid", bus72.out_valid, 0);
        check("rst_acc",   bus72.out_acc, 0);
        check("rst_cnt",   bus72.out_count, 0);
        check("rst_mixed", bus72.out_mixed, 0);
        check("rst_ovf",   bus72.out_ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge", bus72.in_ready, 0);
        @(negedge clk);
        check("ready_after_edge", bus72.in_ready, 1);

        // 3-beat precise burst
        beat(64'd10, 1'b1, 1'b0);
        beat(64'd20, 1'b1, 1'b0);
        beat(64'd30, 1'b1, 1'b1);
        idle(1);
        check("valid_drop", bus72.out_valid, 0);

        // Two max products: fits in 72 bits, saturates 64 bits
        beat('1, 1'b1, 1'b0);
        beat('1, 1'b1, 1'b1);

        // Mixed precision, then single-beat burst
        beat(64'd5, 1'b1, 1'b0);
        beat(64'd6, 1'b0, 1'b0);
        beat(64'd7, 1'b1, 1'b1);
        beat(64'd9, 1'b0, 1'b1);

        // Consumer stall, then handshake together with a new last beat
        beat(64'd100, 1'b0, 1'b1);
        hold_check(5);
        beat(64'd7, 1'b1, 1'b1);

        // Reset mid-burst
        beat(64'd11, 1'b1, 1'b0);
        beat(64'd12, 1'b1, 1'b0);
        rst_n = 1'b0;
        q_prod.delete();
        q_prec.delete();
        #1;
        check("mid_rst_valid", bus72.out_valid, 0);
        check("mid_rst_acc",   bus72.out_acc, 0);
        check("mid_rst_cnt",   bus72.out_count, 0);
        check("mid_rst_ready", bus72.in_ready, 0);
        check("mid_rst_acc64", bus64.out_acc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(64'd5, 1'b1, 1'b1);

        // 100-beat burst with random bubbles
        for (int i = 0; i < 100; i++) begin
            idle($urandom_range(0, 2));
            beat({$urandom, $urandom}, 1'($urandom), i == 99);
        end

        // Short random bursts with random consumer stalls
        for (int b = 0; b < 10; b++) begin
            int len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                beat({$urandom, $urandom}, 1'($urandom), k == len - 1);
            end
            hold_check($urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
